// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Reusable pipeline stage register with valid/ready handshake,
//               flush, split control/data payload and optional skid entry.
//               Control is zeroed on every bubble; data is simply held.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 24,
    parameter int SKID   = 0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              InValid,
    output logic              InReady,
    input  logic [CTRL_W-1:0] InCtrl,
    input  logic [DATA_W-1:0] InData,
    input  logic              Flush,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [DATA_W-1:0] OutData,
    output logic [1:0]        Occupancy
);

    if (SKID == 0) begin : g_single
        logic              r_valid;
        logic [CTRL_W-1:0] r_ctrl;
        logic [DATA_W-1:0] r_data;
        logic              w_accept;
        logic              w_xfer;

        // A single entry can take a new slot whenever it is empty or draining.
        assign InReady  = OutReady | ~r_valid;
        assign w_accept = InValid & InReady;
        assign w_xfer   = r_valid & OutReady;

        // Main entry: flush squashes, accept loads, a bare transfer leaves a bubble.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
                r_data  <= '0;
            end else if (Flush) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_ctrl  <= InCtrl;
                r_data  <= InData;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end
        end

        assign OutValid  = r_valid;
        assign OutCtrl   = r_ctrl;
        assign OutData   = r_data;
        assign Occupancy = {1'b0, r_valid};
    end else begin : g_skid
        logic              r_mainValid;
        logic [CTRL_W-1:0] r_mainCtrl;
        logic [DATA_W-1:0] r_mainData;
        logic              r_skidValid;
        logic [CTRL_W-1:0] r_skidCtrl;
        logic [DATA_W-1:0] r_skidData;
        logic              r_inReady;
        logic              w_accept;
        logic              w_xfer;

        // Ready is a registered "skid empty", so no path from OutReady reaches InReady.
        assign InReady  = r_inReady;
        assign w_accept = InValid & r_inReady;
        assign w_xfer   = r_mainValid & OutReady;

        // Two-entry FIFO: skid refills main first so it is never overtaken.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                r_mainValid <= 1'b0;
                r_mainCtrl  <= '0;
                r_mainData  <= '0;
                r_skidValid <= 1'b0;
                r_skidCtrl  <= '0;
                r_skidData  <= '0;
                r_inReady   <= 1'b1;
            end else if (Flush) begin
                r_mainValid <= 1'b0;
                r_mainCtrl  <= '0;
                r_skidValid <= 1'b0;
                r_skidCtrl  <= '0;
                r_inReady   <= 1'b1;
            end else if (w_xfer && r_skidValid) begin
                // Ready is low while skid is full, so no accept can collide here.
                r_mainValid <= 1'b1;
                r_mainCtrl  <= r_skidCtrl;
                r_mainData  <= r_skidData;
                r_skidValid <= 1'b0;
                r_skidCtrl  <= '0;
                r_inReady   <= 1'b1;
            end else if (w_accept && (!r_mainValid || w_xfer)) begin
                r_mainValid <= 1'b1;
                r_mainCtrl  <= InCtrl;
                r_mainData  <= InData;
            end else if (w_accept) begin
                r_skidValid <= 1'b1;
                r_skidCtrl  <= InCtrl;
                r_skidData  <= InData;
                r_inReady   <= 1'b0;
            end else if (w_xfer) begin
                r_mainValid <= 1'b0;
                r_mainCtrl  <= '0;
            end
        end

        assign OutValid  = r_mainValid;
        assign OutCtrl   = r_mainCtrl;
        assign OutData   = r_mainData;
        assign Occupancy = {1'b0, r_mainValid} + {1'b0, r_skidValid};
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Scoreboard bench for pipe_stage_reg, SKID=0 and SKID=1
//               instances side by side, each against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DW = 160;
    localparam int CW = 24;
    localparam int PW = CW + DW;

    logic clk;
    int   checks   = 0;
    int   failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int inst, input logic [PW-1:0] act, input logic [PW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s skid=%0d act=%h req=%h", nm, inst, act, req);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int S = gi;

        logic          rstN;
        logic          inValid;
        logic          inReady;
        logic [CW-1:0] inCtrl;
        logic [DW-1:0] inData;
        logic          flush;
        logic          outValid;
        logic          outReady;
        logic [CW-1:0] outCtrl;
        logic [DW-1:0] outData;
        logic [1:0]    occ;

        // mdl: what the stage holds; expQ: what downstream still expects to see
        logic [PW-1:0] mdl[$];
        logic [PW-1:0] expQ[$];
        bit            done = 1'b0;

        pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(S)) u_dut (
            .Clk(clk), .Reset_n(rstN),
            .InValid(inValid), .InReady(inReady), .InCtrl(inCtrl), .InData(inData),
            .Flush(flush),
            .OutValid(outValid), .OutReady(outReady), .OutCtrl(outCtrl), .OutData(outData),
            .Occupancy(occ)
        );

        function automatic logic [CW-1:0] ctrlOf(input int val);
            return CW'(32'h00A50000 | val);
        endfunction

        // One clock: drive, check status against the model, then advance the model.
        task automatic step(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                            input bit o, input bit f, output bit acc);
            bit            expRdy;
            bit            xfer;
            logic [CW-1:0] expCtrl;
            @(negedge clk);
            inValid  = v;
            inCtrl   = c;
            inData   = d;
            outReady = o;
            flush    = f;
            #1;
            expRdy  = (S == 1) ? (mdl.size() < 2) : (mdl.size() == 0 || o);
            expCtrl = (mdl.size() > 0) ? mdl[0][PW-1:DW] : '0;
            chk("in_ready",  S, PW'(inReady),  PW'(expRdy));
            chk("occupancy", S, PW'(occ),      PW'(mdl.size()));
            chk("out_valid", S, PW'(outValid), PW'(mdl.size() > 0));
            chk("out_ctrl",  S, PW'(outCtrl),  PW'(expCtrl));
            acc  = v && expRdy && !f && rstN;
            xfer = (mdl.size() > 0) && o;
            @(posedge clk);
            if (!rstN) begin
                mdl.delete();
                expQ.delete();
            end else begin
                if (xfer) void'(mdl.pop_front());
                if (f) begin
                    mdl.delete();
                    expQ.delete();
                end else if (acc) begin
                    mdl.push_back({c, d});
                    expQ.push_back({c, d});
                end
            end
        endtask

        task automatic offer(input int val, input bit o, input bit f);
            bit acc;
            step(1'b1, ctrlOf(val), DW'(val), o, f, acc);
        endtask

        // Values first..first+count-1 back to back, held until taken; OutReady low in the stall window.
        task automatic stream(input int first, input int count, input int stallFrom, input int stallLen);
            int sent = 0;
            bit acc;
            bit o;
            for (int c = 0; c < count + stallLen + 12; c++) begin
                o = !(c >= stallFrom && c < stallFrom + stallLen);
                step(sent < count, ctrlOf(first + sent), DW'(first + sent), o, 1'b0, acc);
                if (acc) sent++;
            end
        endtask

        // Monitor: every transfer must match the oldest outstanding expectation.
        initial begin
            logic [PW-1:0] e;
            forever begin
                @(negedge clk);
                #3;
                if (rstN && outValid && outReady) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL out_spurious skid=%0d act=%h req=none", S, {outCtrl, outData});
                    end else begin
                        e = expQ.pop_front();
                        chk("out_payload", S, {outCtrl, outData}, e);
                    end
                end
            end
        end

        initial begin
            bit            acc;
            bit            pend;
            bit            o;
            bit            f;
            logic [CW-1:0] pc;
            logic [DW-1:0] pd;

            rstN = 1'b0; inValid = 1'b1; inCtrl = '1; inData = '1; outReady = 1'b0; flush = 1'b0;
            // reset held with a valid, all-ones upstream slot
            repeat (3) step(1'b1, '1, '1, 1'b0, 1'b0, acc);
            #2 rstN = 1'b1;

            // streaming 1..8, then backpressure 1..4 with a 3-cycle stall
            stream(1, 8, 100, 0);
            stream(1, 4, 2, 3);

            // flush a full stage with a concurrent offer of 9
            offer(10, 1'b0, 1'b0);
            offer(11, 1'b0, 1'b0);
            offer(9, 1'b0, 1'b1);
            step(1'b0, '0, '0, 1'b0, 1'b0, acc);
            stream(30, 3, 100, 0);

            // flush concurrent with the transfer of 5
            offer(5, 1'b1, 1'b0);
            step(1'b0, '0, '0, 1'b1, 1'b1, acc);
            step(1'b0, '0, '0, 1'b1, 1'b0, acc);

            // asynchronous reset pulse between edges with the stage full
            offer(20, 1'b0, 1'b0);
            offer(21, 1'b0, 1'b0);
            @(negedge clk);
            inValid = 1'b0;
            #2 rstN = 1'b0;
            #1;
            chk("rst_in_ready",  S, PW'(inReady),  PW'(1'b1));
            chk("rst_out_valid", S, PW'(outValid), PW'(1'b0));
            chk("rst_out_ctrl",  S, PW'(outCtrl),  PW'(0));
            chk("rst_out_data",  S, PW'(outData),  PW'(0));
            chk("rst_occupancy", S, PW'(occ),      PW'(0));
            mdl.delete();
            expQ.delete();
            #1 rstN = 1'b1;
            stream(40, 6, 3, 2);

            // randomized traffic with occasional flushes
            pend = 1'b0;
            pc   = '0;
            pd   = '0;
            for (int c = 0; c < 400; c++) begin
                if (!pend && $urandom_range(0, 9) < 7) begin
                    pend = 1'b1;
                    pc   = CW'($urandom) | CW'(1);
                    pd   = {$urandom, $urandom, $urandom, $urandom, $urandom};
                end
                o = ($urandom_range(0, 9) < 7);
                f = ($urandom_range(0, 29) == 0);
                step(pend, pc, pd, o, f, acc);
                if (acc || f) pend = 1'b0;
            end
            repeat (4) step(1'b0, '0, '0, 1'b1, 1'b0, acc);
            chk("leftover", S, PW'(expQ.size()), PW'(0));
            done = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 40000; c++) begin
            @(posedge clk);
            if (g_dut[0].done && g_dut[1].done) break;
        end
        if (!(g_dut[0].done && g_dut[1].done)) begin
            checks++;
            failures++;
            $display("FAIL timeout act=not_done req=done");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
